sar_signed_search: RTL and testbench

//  Successive-approximation driver for a signed less-than comparator: finds an unknown signed
//  N-bit target by issuing one trial value per bit, MSB first, and consuming the comparator's
//  "target < trial" answer. Sits on the requesting side of the comparator; the comparator is
//  any slt-style unit (combinational or multi-cycle) behind a req/ack handshake.

---
 rtl/sar_signed_search_pkg.sv | 11 +
 rtl/sar_signed_search.sv | 64 ++++++
 tb/tb_sar_signed_search.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sar_signed_search_pkg.sv
// sar_signed_search_pkg: shared state encoding and helpers for the signed SAR search driver
package sar_signed_search_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_PROBE = 2'd1;
  localparam state_t S_GAP   = 2'd2;
  localparam state_t S_DONE  = 2'd3;
  function automatic logic [63:0] msb_mask(input int n);
    return 64'd1 << (n - 1);
  endfunction
endpackage

// File: rtl/sar_signed_search.sv
// sar_signed_search: successive-approximation search of a signed target via a req/ack slt comparator
module sar_signed_search
  import sar_signed_search_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         busy,
  output logic         cmp_req,
  output logic [N-1:0] cmp_trial,
  input  logic         cmp_ack,
  input  logic         cmp_lt,
  output logic         done,
  output logic [N-1:0] result
);
  localparam int CW = $clog2(N);
  localparam logic [N-1:0] MSB = N'(msb_mask(N));
  state_t state;
  logic [CW-1:0] idx;
  logic [N-1:0] u, trial, u_nx, nxt_bit;
  always_comb begin
    busy = state != S_IDLE;
    cmp_req = state == S_PROBE;
    done = state == S_DONE;
    cmp_trial = trial;
    u_nx = u;
    u_nx[idx] = ~cmp_lt;
    nxt_bit = N'(1) << (idx - CW'(1));
  end
  // u is offset binary; trials leave the block already converted back to two's complement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx <= CW'(N - 1);
      u <= '0;
      trial <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_PROBE;
          idx <= CW'(N - 1);
          u <= '0;
          trial <= '0;
        end
        S_PROBE: if (cmp_ack) begin
          u <= u_nx;
          if (idx == '0) begin
            state <= S_DONE;
            result <= u_nx ^ MSB;
          end else begin
            state <= S_GAP;
            idx <= idx - CW'(1);
            trial <= (u_nx | nxt_bit) ^ MSB;
          end
        end
        S_GAP: state <= S_PROBE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sar_signed_search.sv
// tb_sar_signed_search: three instances (N=8,16,32) against a prefix-of-target trial model
module tb_sar_signed_search;
  logic clk, rst_n, spur_en;
  logic start [3];
  logic req_s [3], ack_s [3], lt_s [3], busy_s [3], done_s [3];
  logic [31:0] trial_s [3], result_s [3];
  logic signed [31:0] tgt [3];
  int wmax [3], pk [3], ndone [3];
  int asserts, fails;
  logic [7:0] q8 [$], last8 [$];
  logic [7:0] exp1 [8] = '{8'd0, 8'd64, 8'd32, 8'd48, 8'd40, 8'd36, 8'd38, 8'd37};

  initial clk = 0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : 32;
    logic [W-1:0] tw, rw;
    logic [1:0] cnt;
    logic spur, junk;
    assign trial_s[g] = 32'($signed(tw));
    assign result_s[g] = 32'($signed(rw));
    assign ack_s[g] = req_s[g] ? (cnt == 2'd0) : spur;
    assign lt_s[g] = ack_s[g] ? ($signed(tgt[g]) < $signed(trial_s[g])) : junk;
    always @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= 2'd0;
      else if (!req_s[g]) cnt <= 2'($urandom_range(wmax[g], 0));
      else if (cnt != 2'd0) cnt <= cnt - 2'd1;
    initial begin
      spur = 0;
      junk = 0;
      forever begin
        @(negedge clk);
        spur = spur_en && ($urandom_range(1, 0) == 1);
        junk = 1'($urandom);
      end
    end
    sar_signed_search #(.N(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .busy(busy_s[g]),
      .cmp_req(req_s[g]), .cmp_trial(tw), .cmp_ack(ack_s[g]), .cmp_lt(lt_s[g]),
      .done(done_s[g]), .result(rw)
    );
  end

  function automatic int wd(input int g);
    return (g == 0) ? 8 : (g == 1) ? 16 : 32;
  endfunction

  // Trial k keeps the top k bits of the offset-binary target and probes the next bit
  function automatic logic [31:0] exp_trial(input logic [31:0] t, input int k, input int w);
    logic [63:0] m, o, tr;
    m = (64'd1 << w) - 64'd1;
    o = ({32'd0, t} ^ (64'd1 << (w - 1))) & m;
    tr = (o & ~((64'd1 << (w - k)) - 64'd1)) | (64'd1 << (w - 1 - k));
    tr = (tr ^ (64'd1 << (w - 1))) & m;
    if (tr[w-1]) tr = tr | ~m;
    return tr[31:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (!rst_n) begin
          chk($sformatf("rst_busy%0d", g), 32'(busy_s[g]), 32'd0);
          chk($sformatf("rst_req%0d", g), 32'(req_s[g]), 32'd0);
          chk($sformatf("rst_done%0d", g), 32'(done_s[g]), 32'd0);
          chk($sformatf("rst_result%0d", g), result_s[g], 32'd0);
          pk[g] = 0;
          if (g == 0) q8.delete();
        end else begin
          if (req_s[g]) chk($sformatf("trial%0d_%0d", g, pk[g]), trial_s[g], exp_trial(tgt[g], pk[g], wd(g)));
          if (req_s[g] && ack_s[g]) begin
            if (g == 0) q8.push_back(trial_s[0][7:0]);
            pk[g]++;
          end
          if (done_s[g]) begin
            chk($sformatf("result%0d", g), result_s[g], tgt[g]);
            chk($sformatf("nprobe%0d", g), 32'(pk[g]), 32'(wd(g)));
            pk[g] = 0;
            ndone[g]++;
            if (g == 0) begin
              last8 = q8;
              q8.delete();
            end
          end
        end
      end
    end
  end

  task automatic search(input int g, input logic [31:0] t, input int wm, output logic [31:0] r, output int cyc);
    @(negedge clk);
    tgt[g] = t;
    wmax[g] = wm;
    start[g] = 1;
    cyc = 0;
    do begin
      @(negedge clk);
      start[g] = 0;
      cyc++;
    end while (!done_s[g] && cyc < 500);
    if (!done_s[g]) chk("search_timeout", 32'(cyc), 32'd0);
    r = result_s[g];
  endtask

  logic [31:0] r;
  int cyc, n0, guard;
  initial begin
    asserts = 0;
    fails = 0;
    spur_en = 0;
    rst_n = 0;
    for (int g = 0; g < 3; g++) begin
      start[g] = 0;
      tgt[g] = 0;
      wmax[g] = 0;
      pk[g] = 0;
      ndone[g] = 0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    search(0, 32'd37, 0, r, cyc);
    chk("t1_result", {24'd0, r[7:0]}, 32'd37);
    chk("t1_done_cycle", 32'(cyc + 1), 32'd17);
    chk("t1_ntrials", 32'(last8.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("t1_trial%0d", i), 32'(last8[i]), 32'(exp1[i]));
    search(0, -32'sd128, 0, r, cyc);
    chk("t2_min", {24'd0, r[7:0]}, 32'h80);
    search(0, 32'sd127, 2, r, cyc);
    chk("t2_max", {24'd0, r[7:0]}, 32'h7F);
    search(2, -32'sd1, 3, r, cyc);
    chk("t3_minus1", r, 32'hFFFF_FFFF);
    search(2, 32'h8000_0000, 3, r, cyc);
    chk("t3_min32", r, 32'h8000_0000);
    search(2, 32'h7FFF_FFFF, 3, r, cyc);
    chk("t3_max32", r, 32'h7FFF_FFFF);
    search(2, 32'h1234_5678, 3, r, cyc);
    chk("t3_mid32", r, 32'h1234_5678);
    @(negedge clk);
    n0 = ndone[0];
    tgt[0] = 32'sd10;
    wmax[0] = 1;
    start[0] = 1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!done_s[0] && guard < 200);
    @(negedge clk);
    start[0] = 0;
    repeat (30) @(negedge clk);
    chk("t4_one_done", 32'(ndone[0] - n0), 32'd1);
    chk("t4_idle", 32'(busy_s[0]), 32'd0);
    chk("t4_result", {24'd0, result_s[0][7:0]}, 32'd10);
    @(negedge clk);
    tgt[0] = 32'sd99;
    wmax[0] = 0;
    start[0] = 1;
    @(negedge clk);
    start[0] = 0;
    guard = 0;
    while (pk[0] < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("t5_req_async", 32'(req_s[0]), 32'd0);
    chk("t5_busy_async", 32'(busy_s[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    search(0, -32'sd5, 0, r, cyc);
    chk("t5_after_reset", {24'd0, r[7:0]}, 32'hFB);
    spur_en = 1;
    repeat (20) @(negedge clk);
    chk("t6_idle_spur_busy", 32'(busy_s[1]), 32'd0);
    chk("t6_idle_spur_done", 32'(ndone[1]), 32'd0);
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] t;
      t = 32'($signed(16'($urandom)));
      search(1, t, int'($urandom_range(1, 0)), r, cyc);
      chk("t6_random", r, t);
    end
    spur_en = 0;
    chk("t6_ndone", 32'(ndone[1]), 32'd1000);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
